// File: rtl/simon_pkg.sv
// simon_pkg
//   Shared definitions for the SIMON key-schedule block:
//   - Z0..Z4 : the five 62-bit SIMON z-sequences, declared [0:61] so that
//              index 0 is the first bit of the sequence
//   - ks_state_t : key-schedule FSM state encoding
//   - z_seq()    : returns the z-sequence selected by an index 0..4
//   - simon_params_ok() : checks for legal (word, key-words, z, rounds) combinations
package simon_pkg;

    localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [0:61] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [0:61] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [0:61] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

    function automatic logic [0:61] z_seq(input int sel);
        case (sel)
            0:       return Z0;
            1:       return Z1;
            2:       return Z2;
            3:       return Z3;
            default: return Z4;
        endcase
    endfunction

    // Word/key-word pairs follow the published SIMON block/key sizes.
    function automatic bit simon_params_ok(input int w, input int m, input int z, input int r);
        bit pair_ok;
        case (w)
            16:      pair_ok = (m == 4);
            24:      pair_ok = (m == 3) || (m == 4);
            32:      pair_ok = (m == 3) || (m == 4);
            48:      pair_ok = (m == 2) || (m == 3);
            64:      pair_ok = (m == 2) || (m == 3) || (m == 4);
            default: pair_ok = 1'b0;
        endcase
        return pair_ok && (z >= 0) && (z <= 4) && (r >= 1) && (r <= 72);
    endfunction

endpackage

// File: rtl/simon_ks_step.sv
// simon_ks_step
//   Combinational SIMON key-expansion step: produces the next key word from
//   the current key window.
//   Ports:
//     w_first  in  WORD_W  oldest window word  (k[i-m])
//     w_second in  WORD_W  window word 1       (k[i-3] when KEY_WORDS == 4)
//     w_last   in  WORD_W  newest window word  (k[i-1])
//     z_bit    in  1       current z-sequence bit
//     new_word out WORD_W  k[i]
module simon_ks_step
    import simon_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int KEY_WORDS = 4
) (
    input  logic [WORD_W-1:0] w_first,
    input  logic [WORD_W-1:0] w_second,
    input  logic [WORD_W-1:0] w_last,
    input  logic              z_bit,
    output logic [WORD_W-1:0] new_word
);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int r);
        return (x >> r) | (x << (WORD_W - r));
    endfunction

    logic [WORD_W-1:0] tmp0;
    logic [WORD_W-1:0] tmp1;
    logic [WORD_W-1:0] tmp2;

    always_comb begin
        tmp0 = rotr(w_last, 3);
        if (KEY_WORDS == 4) begin
            tmp1 = tmp0 ^ w_second;
        end else begin
            tmp1 = tmp0;
        end
        tmp2     = tmp1 ^ rotr(tmp1, 1);
        new_word = ~w_first ^ tmp2 ^ {{(WORD_W-1){1'b0}}, z_bit} ^ WORD_W'(3);
    end

endmodule

// File: rtl/simon_key_schedule.sv
// simon_key_schedule
//   Sequential SIMON key-schedule generator. Loads a master key on start and
//   streams round keys k[0..ROUNDS-1] over a valid/ready handshake, one per
//   accepted transfer.
//   Ports:
//     clk      in   1        clock, rising edge
//     rst      in   1        asynchronous reset, active-high
//     start    in   1        load key_in and begin (honoured in IDLE only)
//     key_in   in   W*M      master key, word 0 in the least significant bits
//     rk_valid out  1        rk/rk_idx hold a valid round key
//     rk_ready in   1        consumer accepts the current round key
//     abort    in   1        (only with SIMON_KS_ABORT_EN) drop the stream
//     rk       out  W        round key k[rk_idx]
//     rk_idx   out  7        index of rk
//     busy     out  1        stream in progress
//     done     out  1        one-cycle pulse after the final key transfers
//   Build option: define SIMON_KS_ABORT_EN to add the abort input.
//
//   state | meaning
//   IDLE  | waiting for start, no valid key
//   EMIT  | window holds k[rk_idx] in word 0, presented on rk
module simon_key_schedule
    import simon_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int KEY_WORDS = 4,
    parameter int Z_SEQ     = 3,
    parameter int ROUNDS    = 44
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WORD_W*KEY_WORDS-1:0]   key_in,
    output logic                          rk_valid,
    input  logic                          rk_ready,
`ifdef SIMON_KS_ABORT_EN
    input  logic                          abort,
`endif
    output logic [WORD_W-1:0]             rk,
    output logic [6:0]                    rk_idx,
    output logic                          busy,
    output logic                          done
);

    if (!simon_params_ok(WORD_W, KEY_WORDS, Z_SEQ, ROUNDS)) begin : g_param_check
        $error("simon_key_schedule: illegal parameter combination");
    end

    localparam logic [0:61] ZSEL     = z_seq(Z_SEQ);
    localparam logic [6:0]  LAST_IDX = 7'(ROUNDS - 1);

    ks_state_t         state;
    ks_state_t         state_nxt;
    logic [WORD_W-1:0] win [KEY_WORDS];
    logic [WORD_W-1:0] new_word;
    logic [6:0]        idx;
    logic [5:0]        z_idx;
    logic              abort_w;
    logic              fire;
    logic              load;
    logic              done_set;

`ifdef SIMON_KS_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign rk_valid = (state == EMIT);
    assign busy     = (state == EMIT);
    assign rk       = win[0];
    assign rk_idx   = idx;
    assign fire     = rk_valid & rk_ready;

    simon_ks_step #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS)
    ) u_step (
        .w_first  (win[0]),
        .w_second (win[1]),
        .w_last   (win[KEY_WORDS-1]),
        .z_bit    (ZSEL[z_idx]),
        .new_word (new_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort_w) begin
                    state_nxt = EMIT;
                    load      = 1'b1;
                end
            end
            EMIT: begin
                if (abort_w) begin
                    state_nxt = IDLE;
                end else if (fire && (idx == LAST_IDX)) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The window advances on every transfer, including the last one and a
    // transfer coinciding with abort; the stale contents are never presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                win[j] <= '0;
            end
            idx   <= '0;
            z_idx <= '0;
            done  <= 1'b0;
        end else begin
            done <= done_set;
            if (load) begin
                for (int j = 0; j < KEY_WORDS; j++) begin
                    win[j] <= key_in[WORD_W*j +: WORD_W];
                end
                idx   <= '0;
                z_idx <= '0;
            end else if (fire) begin
                for (int j = 0; j < KEY_WORDS-1; j++) begin
                    win[j] <= win[j+1];
                end
                win[KEY_WORDS-1] <= new_word;
                idx              <= idx + 7'd1;
                z_idx            <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_simon_key_schedule.sv
module tb_simon_key_schedule;

    typedef struct {
        int          d;
        int          idx;
        logic [63:0] k;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rk_ready = 1'b1;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic         abort_a = 1'b0, abort_b = 1'b0;
    logic [127:0] key_a = '0;
    logic [255:0] key_b = '0;

    logic         rk_valid_a, busy_a, done_a;
    logic [31:0]  rk_a;
    logic [6:0]   rk_idx_a;
    logic         rk_valid_b, busy_b, done_b;
    logic [63:0]  rk_b;
    logic [6:0]   rk_idx_b;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  ready_mode = 0;
    exp_t sbq[$];
    bit  active[2];
    bit  done_exp[2];
    string z_str[5];

    localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;

    always #5 clk = ~clk;

    simon_key_schedule #(.WORD_W(32), .KEY_WORDS(4), .Z_SEQ(3), .ROUNDS(44)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_a),
        .rk_valid(rk_valid_a), .rk_ready(rk_ready),
`ifdef SIMON_KS_ABORT_EN
        .abort(abort_a),
`endif
        .rk(rk_a), .rk_idx(rk_idx_a), .busy(busy_a), .done(done_a)
    );

    simon_key_schedule #(.WORD_W(64), .KEY_WORDS(4), .Z_SEQ(4), .ROUNDS(72)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_b),
        .rk_valid(rk_valid_b), .rk_ready(rk_ready),
`ifdef SIMON_KS_ABORT_EN
        .abort(abort_b),
`endif
        .rk(rk_b), .rk_idx(rk_idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w,
                                         input logic [63:0] mask);
        return ((x >> r) | (x << (w - r))) & mask;
    endfunction

    // Reference: full key array built from the SIMON recurrence, indexed by round.
    function automatic void gen_keys(input int d, input logic [255:0] key);
        int w, m, z, r;
        logic [63:0] k [80];
        logic [63:0] mask, tmp, zb;
        w = (d == 0) ? 32 : 64;
        m = 4;
        z = (d == 0) ? 3 : 4;
        r = (d == 0) ? 44 : 72;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int j = 0; j < m; j++) k[j] = 64'(key >> (w * j)) & mask;
        for (int i = m; i < r; i++) begin
            tmp = rotr(k[i-1], 3, w, mask);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp = tmp ^ rotr(tmp, 1, w, mask);
            zb  = (z_str[z][(i - m) % 62] == "1") ? 64'd1 : 64'd0;
            k[i] = (~k[i-m] ^ tmp ^ zb ^ 64'd3) & mask;
        end
        for (int i = 0; i < r; i++) sbq.push_back('{d, i, k[i]});
    endfunction

    function automatic void flush(input int d);
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].d == d) sbq.delete(i);
    endfunction

    function automatic bit pending(input int d);
        foreach (sbq[i]) if (sbq[i].d == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mon(input int d, input logic v, input logic [63:0] rkv, input logic [6:0] idxv,
                       input logic bz, input logic dn, input logic st, input logic ab,
                       input logic [255:0] key);
        int last_idx;
        last_idx = (d == 0) ? 43 : 71;
        if (rst) begin
            check($sformatf("rst_valid%0d", d), 64'(v), 64'd0);
            check($sformatf("rst_done%0d", d), 64'(dn), 64'd0);
            active[d]   = 1'b0;
            done_exp[d] = 1'b0;
            flush(d);
            return;
        end
        check($sformatf("valid%0d", d), 64'(v), 64'(active[d]));
        check($sformatf("busy%0d", d), 64'(bz), 64'(active[d]));
        check($sformatf("done%0d", d), 64'(dn), 64'(done_exp[d]));
        done_exp[d] = 1'b0;
        if (active[d]) begin
            if (v) begin
                if (sbq.size() == 0 || sbq[0].d != d) begin
                    timeout($sformatf("sb_empty%0d", d));
                end else begin
                    check($sformatf("rk%0d[%0d]", d, sbq[0].idx), rkv, sbq[0].k);
                    check($sformatf("rk_idx%0d", d), 64'(idxv), 64'(sbq[0].idx));
                    if (rk_ready) begin
                        if (ab) begin
                            void'(sbq.pop_front());
                            active[d] = 1'b0;
                            flush(d);
                        end else if (sbq[0].idx == last_idx) begin
                            void'(sbq.pop_front());
                            active[d]   = 1'b0;
                            done_exp[d] = 1'b1;
                        end else begin
                            void'(sbq.pop_front());
                        end
                    end else if (ab) begin
                        active[d] = 1'b0;
                        flush(d);
                    end
                end
            end
        end else if (st && !ab) begin
            gen_keys(d, key);
            active[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rk_valid_a, {32'b0, rk_a}, rk_idx_a, busy_a, done_a, start_a, abort_a, {128'b0, key_a});
        mon(1, rk_valid_b, rk_b, rk_idx_b, busy_b, done_b, start_b, abort_b, key_b);
    end

    initial begin : ready_drv
        int hold;
        hold = 0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                rk_ready = 1'b1;
            end else if (hold > 0) begin
                rk_ready = 1'b0;
                hold--;
            end else if ($urandom_range(0, 7) == 0) begin
                rk_ready = 1'b0;
                hold = 4;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_idx(input int d, input int n, input string name);
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (d == 0 && rk_valid_a && rk_idx_a == 7'(n)) return;
            if (d == 1 && rk_valid_b && rk_idx_b == 7'(n)) return;
        end
        timeout(name);
    endtask

    task automatic wait_idle(input int d, input string name);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (d == 0 && !busy_a && !pending(0)) return;
            if (d == 1 && !busy_b && !pending(1)) return;
        end
        timeout(name);
    endtask

    task automatic start_stream_a(input logic [127:0] k);
        key_a = k;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        key_a = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        z_str[0] = "11111010001001010110000111001101111101000100101011000011100110";
        z_str[1] = "10001110111110010011000010110101000111011111001001100001011010";
        z_str[2] = "10101111011100000011010010011000101000010001111110010110110011";
        z_str[3] = "11011011101011000110010111100000010010001010011100110100001111";
        z_str[4] = "11010001111001101011011000100000010111000011001010010011101111";

        repeat (3) @(posedge clk);
        #1;
        check("reset_rk", 64'(rk_a), 64'd0);
        check("reset_rk_idx", 64'(rk_idx_a), 64'd0);
        check("reset_valid", 64'(rk_valid_a), 64'd0);
        check("reset_busy", 64'(busy_a), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known 64/128 vector, always ready
        start_stream_a(KEY1);
        check("k0_known", 64'(rk_a), 64'h03020100);
        wait_idx(0, 4, "wait_k4");
        check("k4_known", 64'(rk_a), 64'h70a011c3);
        wait_idle(0, "s1_idle");

        // Same key with random back-pressure
        ready_mode = 1;
        start_stream_a(KEY1);
        wait_idle(0, "s2_idle");
        ready_mode = 0;
        @(posedge clk); #1;

        // start while busy is ignored; start in the done cycle is accepted
        start_stream_a({$urandom, $urandom, $urandom, $urandom});
        wait_idx(0, 10, "wait_idx10");
        key_a = {$urandom, $urandom, $urandom, $urandom};
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_idx(0, 43, "wait_last");
        @(posedge clk); #1;
        check("done_cycle", 64'(done_a), 64'd1);
        start_stream_a({$urandom, $urandom, $urandom, $urandom});
        check("restart_idx", 64'(rk_idx_a), 64'd0);
        wait_idle(0, "s4_idle");

        // Asynchronous reset mid-stream
        start_stream_a({$urandom, $urandom, $urandom, $urandom});
        wait_idx(0, 20, "wait_idx20");
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(rk_valid_a), 64'd0);
        check("async_rst_busy", 64'(busy_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_done", 64'(done_a), 64'd0);

`ifdef SIMON_KS_ABORT_EN
        start_stream_a(KEY1);
        wait_idx(0, 7, "wait_idx7");
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("abort_valid", 64'(rk_valid_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        start_stream_a(KEY1);
        check("abort_restart_k0", 64'(rk_a), 64'h03020100);
        wait_idle(0, "s6_idle");
`endif

        // 128/256 with z4, 72 rounds, random back-pressure
        ready_mode = 1;
        key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_idle(1, "s3_idle");
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
